// File: rtl/sample_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// sample_uart_tx_pkg
// Shared definitions for the sample UART transmitter: sync byte, TX FSM state
// encoding and frame length constants.
// Configuration macro: SAMPLE_UART_TX_CHECKSUM_EN appends an XOR checksum byte
// to every frame (4 bytes instead of 3).
// -----------------------------------------------------------------------------
package sample_uart_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

`ifdef SAMPLE_UART_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;

  // Checksum covers the sync byte plus both sample bytes.
  function automatic logic [7:0] frame_checksum(input logic [15:0] sample);
    return SYNC_BYTE ^ sample[15:8] ^ sample[7:0];
  endfunction
`else
  localparam int FRAME_BYTES = 3;
`endif

  // Index of the final byte in a frame (byte_idx runs 0..LAST_BYTE).
  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO for filtered samples.
// Ports:
//   clk, i_rstn         clock, asynchronous active-low reset
//   wr_en, wr_data      write request; ignored while full
//   rd_en, rd_data      read request; ignored while empty; rd_data shows head
//   count               number of stored entries (0..FIFO_DEPTH)
//   full, empty         status flags derived from the registered count
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          i_rstn,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags come from the registered count only, so a pop in the same cycle
  // never lets a write into a full FIFO.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_uart_tx.sv
// -----------------------------------------------------------------------------
// sample_uart_tx
// Buffers averaged samples from the filter and sends each one as a UART frame:
// sync byte 8'hA5, sample[15:8], sample[7:0] (plus an XOR checksum byte when
// SAMPLE_UART_TX_CHECKSUM_EN is defined). 8N1, LSB first, idle high.
//
// Handshake: a sample is taken on a rising clk edge where data_valid and
// data_ready are both high. data_ready depends only on the registered FIFO
// count; data_valid with data_ready low loses the sample and raises o_drop
// in that same cycle.
//
// Ports:
//   clk, i_rstn   clock, asynchronous active-low reset
//   data_in       sample (DATA_WIDTH bits, zero-extended to 16 for framing)
//   data_valid    data_in valid
//   data_ready    FIFO not full
//   o_tx          UART TX line (registered, idle high)
//   busy          frame in progress or samples queued (registered)
//   o_drop        sample rejected this cycle
//   dbg_state     current TX FSM state
//   dbg_count     current FIFO occupancy
// Parameters: DATA_WIDTH 8..16, CLK_FREQ/BAUD >= 4, FIFO_DEPTH power of two >= 2.
// Configuration macro: SAMPLE_UART_TX_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module sample_uart_tx
  import sample_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        i_rstn,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        o_tx,
  output logic                        busy,
  output logic                        o_drop,
  output tx_state_t                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  logic [DATA_WIDTH-1:0]       fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;

  tx_state_t                   state;
  logic [BAUD_W-1:0]           baud_cnt;
  logic [2:0]                  bit_idx;
  logic [1:0]                  byte_idx;
  logic [15:0]                 hold;
  logic [7:0]                  cur_byte;
  logic                        tx_bit;
  logic                        bit_done;

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rstn  (i_rstn),
    .wr_en   (data_valid),
    .wr_data (data_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_ready = !fifo_full;
  assign o_drop     = data_valid && fifo_full;
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign bit_done   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign dbg_state  = state;
  assign dbg_count  = fifo_count;

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      2'd1:    cur_byte = hold[15:8];
      2'd2:    cur_byte = hold[7:0];
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
      2'd3:    cur_byte = frame_checksum(hold);
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      ST_START: tx_bit = 1'b0;
      ST_DATA:  tx_bit = cur_byte[bit_idx];
      default:  tx_bit = 1'b1;
    endcase
  end

  // o_tx and busy are registered copies of the current state's line level and
  // activity, so the line trails the FSM by one cycle (pop at N+1, start bit
  // at N+2 for a sample accepted at edge N).
  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hold     <= '0;
      o_tx     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      o_tx <= tx_bit;
      busy <= (state != ST_IDLE) || (fifo_count != '0);
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            hold     <= 16'(fifo_dout);
            byte_idx <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
